// File: rtl/can_error_sequencer_if.sv
// Handshake/bus bundle for the CAN error sequencer.
// Sample-point inputs, frame status pulses and sequencer outputs.
interface can_error_sequencer_if;
  logic       SP;
  logic       RX;
  logic       ERROR;
  logic       TX_ROLE;
  logic       RX_OK;
  logic       TX_OK;
  logic       TX_BIT;
  logic       DEC_HOLD;
  logic       ERR_PASSIVE;
  logic       BUS_OFF;
  logic [8:0] TEC;
  logic [7:0] REC;

  modport master (
    output SP, RX, ERROR, TX_ROLE, RX_OK, TX_OK,
    input  TX_BIT, DEC_HOLD, ERR_PASSIVE, BUS_OFF, TEC, REC
  );

  modport slave (
    input  SP, RX, ERROR, TX_ROLE, RX_OK, TX_OK,
    output TX_BIT, DEC_HOLD, ERR_PASSIVE, BUS_OFF, TEC, REC
  );
endinterface

// File: rtl/can_error_sequencer.sv
// CAN fault confinement and error-frame sequencer.
// Drives error flag/delimiter, holds decoder, keeps TEC/REC.
module can_error_sequencer #(
  parameter int FLAG_BITS  = 6,
  parameter int DELIM_BITS = 8,
  parameter int RECOV_SEQS = 128
) (
  input  logic clock,
  input  logic reset,
  can_error_sequencer_if.slave bus
);

  localparam int MAXB = (FLAG_BITS > DELIM_BITS) ? FLAG_BITS : DELIM_BITS;
  localparam int CW   = $clog2(MAXB + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLAG,
    S_WAIT_DELIM,
    S_DELIM,
    S_BUS_OFF
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]     run_cnt_q, run_cnt_d;
  logic [7:0]     seq_cnt_q, seq_cnt_d;
  logic [8:0]     tec_q, tec_d;
  logic [7:0]     rec_q, rec_d;
  logic           tx_bit_q, tx_bit_d;
  logic           dec_hold_q, dec_hold_d;
  logic           err_hit;
  logic           passive_d;

  // Next state, counters and registered bus outputs.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    run_cnt_d = run_cnt_q;
    seq_cnt_d = seq_cnt_q;
    tec_d     = tec_q;
    rec_d     = rec_q;
    err_hit   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.SP && bus.ERROR) begin
          state_d   = S_FLAG;
          bit_cnt_d = '0;
          err_hit   = 1'b1;
        end
      end
      S_FLAG: begin
        if (bus.SP) begin
          if (bit_cnt_q == CW'(FLAG_BITS - 1)) begin
            state_d   = S_WAIT_DELIM;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
      end
      S_WAIT_DELIM: begin
        if (bus.SP && bus.RX) begin
          state_d   = S_DELIM;
          bit_cnt_d = CW'(1);
        end
      end
      S_DELIM: begin
        if (bus.SP) begin
          if (bus.RX) begin
            if (bit_cnt_q == CW'(DELIM_BITS - 1)) begin
              state_d   = S_IDLE;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + CW'(1);
            end
          end else begin
            // dominant inside the delimiter is a form error
            state_d   = S_FLAG;
            bit_cnt_d = '0;
            err_hit   = 1'b1;
          end
        end
      end
      S_BUS_OFF: begin
        if (bus.SP) begin
          if (!bus.RX) begin
            run_cnt_d = '0;
          end else if (run_cnt_q == 4'd10) begin
            run_cnt_d = '0;
            if (seq_cnt_q == 8'(RECOV_SEQS - 1)) begin
              seq_cnt_d = '0;
              tec_d     = '0;
              rec_d     = '0;
              state_d   = S_IDLE;
            end else begin
              seq_cnt_d = seq_cnt_q + 8'd1;
            end
          end else begin
            run_cnt_d = run_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // an accepted error masks any decrement on the same clock
    if (err_hit) begin
      if (bus.TX_ROLE) begin
        tec_d = tec_q + 9'd8;
      end else if (rec_q != 8'hff) begin
        rec_d = rec_q + 8'd1;
      end
    end else if (state_q != S_BUS_OFF) begin
      if (bus.RX_OK) begin
        if (rec_q > 8'd127) begin
          rec_d = 8'd119;
        end else if (rec_q != 8'd0) begin
          rec_d = rec_q - 8'd1;
        end
      end
      if (bus.TX_OK && tec_q != 9'd0) begin
        tec_d = tec_q - 9'd1;
      end
    end

    if (state_q != S_BUS_OFF && tec_q > 9'd255) begin
      state_d   = S_BUS_OFF;
      bit_cnt_d = '0;
      run_cnt_d = '0;
      seq_cnt_d = '0;
    end

    // flag level follows the confinement state it will be sent under
    passive_d  = (tec_d > 9'd127) || (rec_d > 8'd127);
    tx_bit_d   = 1'b1;
    dec_hold_d = 1'b1;
    unique case (state_d)
      S_IDLE:  dec_hold_d = 1'b0;
      S_FLAG:  tx_bit_d   = passive_d;
      default: tx_bit_d   = 1'b1;
    endcase
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      run_cnt_q  <= '0;
      seq_cnt_q  <= '0;
      tec_q      <= '0;
      rec_q      <= '0;
      tx_bit_q   <= 1'b1;
      dec_hold_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      run_cnt_q  <= run_cnt_d;
      seq_cnt_q  <= seq_cnt_d;
      tec_q      <= tec_d;
      rec_q      <= rec_d;
      tx_bit_q   <= tx_bit_d;
      dec_hold_q <= dec_hold_d;
    end
  end

  assign bus.TX_BIT      = tx_bit_q;
  assign bus.DEC_HOLD    = dec_hold_q;
  assign bus.TEC         = tec_q;
  assign bus.REC         = rec_q;
  assign bus.BUS_OFF     = (state_q == S_BUS_OFF);
  assign bus.ERR_PASSIVE = ((tec_q > 9'd127) || (rec_q > 8'd127))
                           && (state_q != S_BUS_OFF);

endmodule
